// File: rtl/vga_timing_generator.sv
// 640x480@60 VGA raster timing: pixel divider, H/V counters, blanked and sync-aligned color.
// Latency: HSync/VSync/Active/ColorOut lag PixelX/PixelY by one pixel period; no backpressure (free-running raster).
// Optional VGA_TEST_PATTERN_EN: TestMode=1 swaps PixelColor for eight vertical color bars.
module vga_timing_generator #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        TestMode,
  input  logic [11:0] PixelColor,
  output logic [9:0]  PixelX,
  output logic [9:0]  PixelY,
  output logic        PixelTick,
  output logic        HSync,
  output logic        VSync,
  output logic        Active,
  output logic [11:0] ColorOut,
  output logic        FrameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // 11-bit bounds so a sync end landing exactly on 1024 still compares correctly
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_nxt;
  logic             h_wrap;
  logic             v_wrap;
  logic             active_nxt;
  logic             hsync_nxt;
  logic             vsync_nxt;
  logic [11:0]      color_src;

  always_comb begin
    div_nxt    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    h_wrap     = (PixelX == H_LAST);
    v_wrap     = (PixelY == V_LAST);
    active_nxt = ({1'b0, PixelX} < H_VIS) && ({1'b0, PixelY} < V_VIS);
    hsync_nxt  = !(({1'b0, PixelX} >= HS_START) && ({1'b0, PixelX} < HS_END));
    vsync_nxt  = !(({1'b0, PixelY} >= VS_START) && ({1'b0, PixelY} < VS_END));
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [9:0]  bar_idx;
  logic [11:0] bar_color;

  assign bar_idx = PixelX / 10'(BAR_W);

  always_comb begin
    bar_color = 12'h000;
    case (bar_idx)
      10'd0:   bar_color = 12'hFFF;
      10'd1:   bar_color = 12'hFF0;
      10'd2:   bar_color = 12'h0FF;
      10'd3:   bar_color = 12'h0F0;
      10'd4:   bar_color = 12'hF0F;
      10'd5:   bar_color = 12'hF00;
      10'd6:   bar_color = 12'h00F;
      default: bar_color = 12'h000;
    endcase
  end

  assign color_src = TestMode ? bar_color : PixelColor;
`else
  logic unused_testmode;
  assign unused_testmode = TestMode;
  assign color_src       = PixelColor;
`endif

  // PixelTick is registered as (next divider == last) so it equals (divider == last) outside reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      div_q      <= '0;
      PixelTick  <= 1'b0;
      PixelX     <= '0;
      PixelY     <= '0;
      HSync      <= 1'b1;
      VSync      <= 1'b1;
      Active     <= 1'b0;
      ColorOut   <= '0;
      FrameStart <= 1'b0;
    end else begin
      div_q      <= div_nxt;
      PixelTick  <= (div_nxt == DIV_LAST);
      FrameStart <= 1'b0;
      if (PixelTick) begin
        PixelX <= h_wrap ? '0 : PixelX + 10'd1;
        if (h_wrap) begin
          PixelY <= v_wrap ? '0 : PixelY + 10'd1;
        end
        HSync      <= hsync_nxt;
        VSync      <= vsync_nxt;
        Active     <= active_nxt;
        ColorOut   <= active_nxt ? color_src : 12'h000;
        FrameStart <= h_wrap && v_wrap;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench: default-size instance checked from a vector table, small-raster instance checked against an arithmetic model.
module tb_vga_timing_generator;

  localparam int SD  = 2;
  localparam int SHA = 16, SHF = 2, SHS = 3, SHB = 3;
  localparam int SVA = 6,  SVF = 2, SVS = 2, SVB = 2;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;
  localparam int SF  = SHT * SVT;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic        d_rst, d_tm, d_tick, d_hs, d_vs, d_act, d_fs;
  logic [9:0]  d_x, d_y;
  logic [11:0] d_pc, d_col;

  logic        s_rst, s_tm, s_tick, s_hs, s_vs, s_act, s_fs;
  logic [9:0]  s_x, s_y;
  logic [11:0] s_pc, s_col;

  assign d_pc = {2'b00, d_x};

  vga_timing_generator dut (
    .Clock(Clock), .Reset(d_rst), .TestMode(d_tm), .PixelColor(d_pc),
    .PixelX(d_x), .PixelY(d_y), .PixelTick(d_tick), .HSync(d_hs), .VSync(d_vs),
    .Active(d_act), .ColorOut(d_col), .FrameStart(d_fs)
  );

  vga_timing_generator #(
    .CLK_DIV(SD), .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) dut_s (
    .Clock(Clock), .Reset(s_rst), .TestMode(s_tm), .PixelColor(s_pc),
    .PixelX(s_x), .PixelY(s_y), .PixelTick(s_tick), .HSync(s_hs), .VSync(s_vs),
    .Active(s_act), .ColorOut(s_col), .FrameStart(s_fs)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Default-size instance: k = clock edges since reset release
  typedef struct {
    int k; int tick; int x; int y; int hs; int vs; int act; int col;
  } dvec_t;
  dvec_t tbl[$];
  int dk;

  task automatic step_d();
    @(posedge Clock);
    #1;
    dk++;
  endtask

  // Small-instance reference: edges since release and completed pixel ticks
  int          mk, mt;
  logic [11:0] mcol;

`ifdef VGA_TEST_PATTERN_EN
  function automatic logic [11:0] bar_color(input int x);
    logic [11:0] bars [8];
    int idx;
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    idx  = x / (SHA / 8);
    return (idx < 8) ? bars[idx] : 12'h000;
  endfunction
`endif

  function automatic logic [36:0] s_obs();
    return {s_x, s_y, s_tick, s_hs, s_vs, s_act, s_col, s_fs};
  endfunction

  task automatic step_s();
    logic [11:0] src;
    int p, q, qx, qy, ex, ey;
    logic etick, ehs, evs, eact, efs;
    logic [11:0] ecol;
    @(posedge Clock);
    if (s_rst) begin
      mk = 0; mt = 0; mcol = '0;
    end else begin
      mk++;
      if (mk % SD == 0) begin
        src = s_pc;
`ifdef VGA_TEST_PATTERN_EN
        if (s_tm) src = bar_color((mt % SF) % SHT);
`endif
        mcol = src;
        mt++;
      end
    end
    #1;
    p = mt % SF; ex = p % SHT; ey = p / SHT;
    etick = ((mk + 1) % SD == 0);
    efs   = (mk > 0) && (mk % SD == 0) && (mt > 0) && (p == 0);
    if (mt == 0) begin
      ehs = 1'b1; evs = 1'b1; eact = 1'b0; ecol = '0;
    end else begin
      q = (mt - 1) % SF; qx = q % SHT; qy = q / SHT;
      ehs  = !(qx >= SHA + SHF && qx < SHA + SHF + SHS);
      evs  = !(qy >= SVA + SVF && qy < SVA + SVF + SVS);
      eact = (qx < SHA) && (qy < SVA);
      ecol = eact ? mcol : 12'h000;
    end
    chk($sformatf("model_k%0d_t%0d", mk, mt), 64'(s_obs()),
        64'({10'(ex), 10'(ey), etick, ehs, evs, eact, ecol, efs}));
  endtask

  initial begin
    int n, lows;
    bit seen;

    tbl.push_back('{0,    0, 0,   0, 1, 1, 0, 12'h000});
    tbl.push_back('{2,    0, 0,   0, 1, 1, 0, 12'h000});
    tbl.push_back('{3,    1, 0,   0, 1, 1, 0, 12'h000});
    tbl.push_back('{4,    0, 1,   0, 1, 1, 1, 12'h000});
    tbl.push_back('{21,   0, 5,   0, 1, 1, 1, 12'h004});
    tbl.push_back('{2560, 0, 640, 0, 1, 1, 1, 12'h27F});
    tbl.push_back('{2564, 0, 641, 0, 1, 1, 0, 12'h000});
    tbl.push_back('{2624, 0, 656, 0, 1, 1, 0, 12'h000});
    tbl.push_back('{2628, 0, 657, 0, 0, 1, 0, 12'h000});
    tbl.push_back('{3008, 0, 752, 0, 0, 1, 0, 12'h000});
    tbl.push_back('{3012, 0, 753, 0, 1, 1, 0, 12'h000});
    tbl.push_back('{3199, 1, 799, 0, 1, 1, 0, 12'h000});
    tbl.push_back('{3200, 0, 0,   1, 1, 1, 0, 12'h000});
    tbl.push_back('{3204, 0, 1,   1, 1, 1, 1, 12'h000});
    tbl.push_back('{3208, 0, 2,   1, 1, 1, 1, 12'h001});

    d_rst = 1'b1; d_tm = 1'b0;
    s_rst = 1'b1; s_tm = 1'b0; s_pc = '0;
    repeat (3) @(posedge Clock);
    #1;
    chk("reset_framestart", 64'(d_fs), 64'(0));
    d_rst = 1'b0;
    dk = 0;

    foreach (tbl[i]) begin
      while (dk < tbl[i].k) step_d();
      chk($sformatf("vec%0d_tick", i), 64'(d_tick), 64'(tbl[i].tick));
      chk($sformatf("vec%0d_x", i),    64'(d_x),    64'(tbl[i].x));
      chk($sformatf("vec%0d_y", i),    64'(d_y),    64'(tbl[i].y));
      chk($sformatf("vec%0d_hs", i),   64'(d_hs),   64'(tbl[i].hs));
      chk($sformatf("vec%0d_vs", i),   64'(d_vs),   64'(tbl[i].vs));
      chk($sformatf("vec%0d_act", i),  64'(d_act),  64'(tbl[i].act));
      chk($sformatf("vec%0d_col", i),  64'(d_col),  64'(tbl[i].col));
    end

    // One full line of pixel ticks: HSync low for exactly H_SYNC of them
    lows = 0;
    for (int i = 0; i < 4 * 800; i++) begin
      step_d();
      if (dk % 4 == 0 && d_hs == 1'b0) lows++;
    end
    chk("hsync_low_ticks", 64'(lows), 64'(96));
    d_rst = 1'b1;

    // Small raster: random color/TestMode with occasional resets
    mk = 0; mt = 0; mcol = '0;
    step_s();
    step_s();
    for (int i = 0; i < 2500; i++) begin
      s_rst = ($urandom_range(0, 399) == 0);
      s_tm  = 1'($urandom);
      s_pc  = 12'($urandom);
      step_s();
    end

    // Mid-frame reset: everything back to reset values on the next edge
    s_rst = 1'b0; s_tm = 1'b0; s_pc = 12'hABC;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      step_s();
      seen = (s_y == 10'd5);
    end
    chk("midframe_reach_y5", 64'(seen), 64'(1));
    s_rst = 1'b1;
    step_s();
    chk("midframe_reset_vals", 64'(s_obs()), 64'({10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0}));
    s_rst = 1'b0;

    // First FrameStart only after a whole raster from (0,0)
    n = -1;
    for (int i = 0; i < 2 * SD * SF && n < 0; i++) begin
      step_s();
      if (s_fs) n = mk;
    end
    chk("first_frame_clocks", 64'(n), 64'(SD * SF));

    // Next frame period, counting VSync-low pixel ticks
    n = -1; lows = 0;
    for (int i = 0; i < 2 * SD * SF && n < 0; i++) begin
      step_s();
      if (mk % SD == 0 && s_vs == 1'b0) lows++;
      if (s_fs) n = mk;
    end
    chk("frame_period_clocks", 64'(n), 64'(2 * SD * SF));
    chk("vsync_low_ticks", 64'(lows), 64'(SVS * SHT));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Generates 640x480@60 Hz VGA raster timing from the system Clock and supplies pixel coordinates to the frame/pixel source. It registers the returned 12-bit color word, blanks it outside the visible area, and aligns it with HSync/VSync. It sits directly upstream of the VGA pin interface: its ColorOut drives that stage's 12-bit Color input, and its HSync/VSync go straight to the connector pins.

## Interface
- CLK_DIV, 4: Clock cycles per pixel (100 MHz → 25 MHz); must be ≥1
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, pixels
- H_SYNC, 96: horizontal sync width, pixels
- H_BP, 48: horizontal back porch, pixels
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch, lines
- V_SYNC, 2: vertical sync width, lines
- V_BP, 33: vertical back porch, lines

Ports:
- Clock  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- TestMode  in  1  selects color-bar pattern; only used with VGA_TEST_PATTERN_EN
- PixelColor  in  12  color for current PixelX/PixelY, {R[3:0],G[3:0],B[3:0]}; combinational response from upstream
- PixelX  out  10  current horizontal count, 0..H_TOTAL-1
- PixelY  out  10  current vertical count, 0..V_TOTAL-1
- PixelTick  out  1  one-Clock pulse per pixel period
- HSync  out  1  horizontal sync, active low
- VSync  out  1  vertical sync, active low
- Active  out  1  high while the registered pixel is visible
- ColorOut  out  12  blanked, registered color to the pin-interface stage
- FrameStart  out  1  one-Clock pulse at frame wrap

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider counts 0..CLK_DIV-1. PixelTick = (divider == CLK_DIV-1). With CLK_DIV=1, PixelTick is constantly high.
- Counters update only on PixelTick:
  - HCount increments and wraps H_TOTAL-1→0.
  - On an HCount wrap, VCount increments and wraps V_TOTAL-1→0.
- PixelX = HCount, PixelY = VCount. Both are driven directly from the counter registers.
- Per-pixel registered outputs load on the same PixelTick edge, from the pre-increment counter values and PixelColor:
  - HSync = 0 iff H_ACTIVE+H_FP ≤ HCount < H_ACTIVE+H_FP+H_SYNC (656..751).
  - VSync = 0 iff V_ACTIVE+V_FP ≤ VCount < V_ACTIVE+V_FP+V_SYNC (490..491).
  - Active = (HCount < H_ACTIVE) && (VCount < V_ACTIVE).
  - ColorOut = Active ? PixelColor : 12'h000.
- FrameStart pulses high for one Clock on the PixelTick where HCount=H_TOTAL-1 and VCount=V_TOTAL-1.
- No state machine beyond the counters. Registered outputs hold their values between ticks.

## Timing
- Reset: divider=0, HCount=0, VCount=0, PixelTick=0, HSync=1, VSync=1, Active=0, ColorOut=0, FrameStart=0.
- First PixelTick occurs CLK_DIV Clocks after Reset deasserts.
- Reset asserted mid-frame: every output returns to its reset value on the next edge, and the raster restarts at (0,0). No partial line is completed.
- Latency: HSync/VSync/Active/ColorOut reflect the coordinates PixelX/PixelY held during the preceding pixel period. This is one pixel period, and all four outputs are mutually aligned.
- PixelColor is sampled only on the PixelTick Clock edge; its value at other times is ignored.
- PixelX/PixelY wrap simultaneously at (799,524)→(0,0) on the same edge FrameStart is asserted.
- Counter widths: 10 bits. H_TOTAL and V_TOTAL must be ≤1024.

## Configuration
- VGA_TEST_PATTERN_EN defined:
  - When TestMode=1, PixelColor is replaced by eight vertical color bars of width H_ACTIVE/8.
  - Bar index = HCount/80 (default parameters).
  - Bar colors in order: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - Blanking still applies.
- Undefined: TestMode is ignored, PixelColor is always used, and no bar logic is synthesized.

## Test plan
- Reset, then release with CLK_DIV=4: outputs hold reset values; first PixelTick on Clock 4. After 800 ticks, PixelY=1 and PixelX=0.
- Full frame: count Clocks between FrameStart pulses = 4·800·525 = 1,680,000. Per line, HSync is low for exactly 96 ticks starting after HCount=656 is sampled. Per frame, VSync is low for exactly 2 lines (490, 491).
- Blanking: PixelColor=12'hABC constant; ColorOut=ABC for 640×480 pixels per frame and 000 elsewhere, Active matching.
- Alignment: PixelColor = {2'b0, PixelX}. ColorOut after the tick at PixelX=639 equals 27F; after the tick at PixelX=640 it equals 000.
- Reset mid-frame at PixelY=300: on the next Clock all outputs are at reset values; FrameStart stays 0 until a full 800×525 raster elapses.
- With VGA_TEST_PATTERN_EN and TestMode=1: ColorOut=FFF for pixels 0..79, FF0 for 80..159, and 000 for 560..639 on a visible line. With the macro undefined, the same stimulus yields PixelColor.
